// File: rtl/csi_rx_link_supervisor.sv
// CSI-2 receive link supervisor: sequences datapath reset and enable, declares
// lock on the first good packet, and retrains on packet timeout or repeated ECC failures.
//
// Ports:
//   clock, reset_n      - single clock, asynchronous active-low reset
//   link_en             - software link enable (level)
//   sync_wait           - packet handler hunting for sync (status only)
//   packet_done, ecc_ok - end-of-packet pulse and header ECC result
//   in_frame            - high between FS and FE
//   dp_reset, dp_enable - datapath reset / enable (state decode)
//   link_up, hunting    - lock status; hunting = link_up & sync_wait
//   retrain_cnt         - timeout/ECC retrains, saturating
//   ecc_err_cnt         - ECC-failed packets, saturating
//   frame_cnt           - frame starts seen while locked, wrapping
module csi_rx_link_supervisor #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int ERR_LIMIT   = 4,
    parameter int HOLD_CYC    = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        link_en,
    input  logic        sync_wait,
    input  logic        packet_done,
    input  logic        ecc_ok,
    input  logic        in_frame,
    output logic        dp_reset,
    output logic        dp_enable,
    output logic        link_up,
    output logic        hunting,
    output logic [7:0]  retrain_cnt,
    output logic [15:0] ecc_err_cnt,
    output logic [15:0] frame_cnt
);

    localparam int WD_W   = $clog2(TIMEOUT_CYC);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [ERR_W-1:0]  ERR_LIM   = ERR_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        S_OFF,
        S_RESET,
        S_ACQ,
        S_LOCK
    } state_t;

    state_t             r_state;
    logic [WD_W-1:0]    r_wd;
    logic [HOLD_W-1:0]  r_hold;
    logic [ERR_W-1:0]   r_err;
    logic [7:0]         r_retrain;
    logic [15:0]        r_ecc_errs;
    logic [15:0]        r_frames;
    logic               r_in_frame_q;

    logic               w_active;
    logic               w_bad;
    logic               w_good;
    logic [ERR_W-1:0]   w_err_inc;
    logic               w_trig_a;
    logic               w_trig_b;
    logic               w_retrain;
    logic               w_fs_rise;

    assign w_active  = (r_state == S_ACQ) || (r_state == S_LOCK);
    assign w_bad     = w_active && packet_done && !ecc_ok;
    assign w_good    = w_active && packet_done && ecc_ok;
    assign w_err_inc = r_err + 1'b1;
    // A packet in the expiry cycle rescues the watchdog.
    assign w_trig_a  = w_active && !packet_done && (r_wd == WD_LAST);
    assign w_trig_b  = w_bad && (w_err_inc == ERR_LIM);
    assign w_retrain = w_trig_a || w_trig_b;
    assign w_fs_rise = in_frame && !r_in_frame_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_OFF;
            r_wd         <= '0;
            r_hold       <= '0;
            r_err        <= '0;
            r_retrain    <= '0;
            r_ecc_errs   <= '0;
            r_frames     <= '0;
            r_in_frame_q <= 1'b0;
        end else begin
            r_in_frame_q <= in_frame;
            if (r_state == S_LOCK && w_fs_rise) begin
                r_frames <= r_frames + 16'd1;
            end

            // Disable overrides everything and is not a retrain.
            if (!link_en) begin
                r_state <= S_OFF;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_state <= S_RESET;
                        r_hold  <= '0;
                    end
                    S_RESET: begin
                        if (r_hold == HOLD_LAST) begin
                            r_state <= S_ACQ;
                            r_wd    <= '0;
                            r_err   <= '0;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    S_ACQ, S_LOCK: begin
                        if (w_bad && r_ecc_errs != 16'hFFFF) begin
                            r_ecc_errs <= r_ecc_errs + 16'd1;
                        end
                        if (w_retrain) begin
                            r_state <= S_RESET;
                            r_hold  <= '0;
                            if (r_retrain != 8'hFF) begin
                                r_retrain <= r_retrain + 8'd1;
                            end
                        end else begin
                            if (packet_done) begin
                                r_wd <= '0;
                            end else begin
                                r_wd <= r_wd + 1'b1;
                            end
                            if (w_good) begin
                                r_err   <= '0;
                                r_state <= S_LOCK;
                            end else if (w_bad) begin
                                r_err <= w_err_inc;
                            end
                        end
                    end
                    default: r_state <= S_OFF;
                endcase
            end
        end
    end

    assign dp_reset    = (r_state == S_OFF) || (r_state == S_RESET);
    assign dp_enable   = w_active;
    assign link_up     = (r_state == S_LOCK);
    assign hunting     = link_up && sync_wait;
    assign retrain_cnt = r_retrain;
    assign ecc_err_cnt = r_ecc_errs;
    assign frame_cnt   = r_frames;

endmodule

// File: tb/tb_csi_rx_link_supervisor.sv
// Directed bench for csi_rx_link_supervisor.
// Vector table plus hand sequences for saturation and async reset.
module tb_csi_rx_link_supervisor;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        link_en = 1'b0;
    logic        sync_wait = 1'b0;
    logic        packet_done = 1'b0;
    logic        ecc_ok = 1'b0;
    logic        in_frame = 1'b0;
    logic        dp_reset;
    logic        dp_enable;
    logic        link_up;
    logic        hunting;
    logic [7:0]  retrain_cnt;
    logic [15:0] ecc_err_cnt;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad = 0;

    csi_rx_link_supervisor #(
        .TIMEOUT_CYC(100),
        .ERR_LIMIT(4),
        .HOLD_CYC(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .link_en(link_en),
        .sync_wait(sync_wait),
        .packet_done(packet_done),
        .ecc_ok(ecc_ok),
        .in_frame(in_frame),
        .dp_reset(dp_reset),
        .dp_enable(dp_enable),
        .link_up(link_up),
        .hunting(hunting),
        .retrain_cnt(retrain_cnt),
        .ecc_err_cnt(ecc_err_cnt),
        .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          n;
        logic        en, pd, ok, fr, sw;
        logic [43:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [43:0] mk(
        input logic rst, ena, up, hu,
        input int ecc, ret, frm);
        return {rst, ena, up, hu, 16'(ecc), 8'(ret), 16'(frm)};
    endfunction

    function automatic void add(
        input int n, input logic en, pd, ok, fr, sw,
        input logic [43:0] e);
        vec_t v;
        v.n = n; v.en = en; v.pd = pd; v.ok = ok;
        v.fr = fr; v.sw = sw; v.exp = e;
        vq.push_back(v);
    endfunction

    task automatic step(input int n, input logic en, pd, ok, fr, sw);
        @(negedge clock);
        link_en = en; packet_done = pd; ecc_ok = ok;
        in_frame = fr; sync_wait = sw;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [43:0] e);
        logic [43:0] act;
        act = {dp_reset, dp_enable, link_up, hunting,
               ecc_err_cnt, retrain_cnt, frame_cnt};
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got rst/en/up/hu=%b ecc=%0d ret=%0d frm=%0d want rst/en/up/hu=%b ecc=%0d ret=%0d frm=%0d",
                name, act[43:40], act[39:24], act[23:16], act[15:0],
                e[43:40], e[39:24], e[23:16], e[15:0]);
        end
    endtask

    initial begin
        // n, en,pd,ok,fr,sw | rst,ena,up,hu, ecc,ret,frm
        add(1,  0,0,0,0,0, mk(1,0,0,0, 0,0,0));
        add(1,  1,0,0,0,0, mk(1,0,0,0, 0,0,0));
        add(15, 1,0,0,0,0, mk(1,0,0,0, 0,0,0));
        add(1,  1,0,0,0,0, mk(0,1,0,0, 0,0,0));
        add(1,  1,1,0,0,0, mk(0,1,0,0, 1,0,0));
        add(3,  1,0,0,0,0, mk(0,1,0,0, 1,0,0));
        add(1,  1,1,1,0,0, mk(0,1,1,0, 1,0,0));
        add(1,  1,0,0,0,1, mk(0,1,1,1, 1,0,0));
        add(1,  1,1,0,0,0, mk(0,1,1,0, 2,0,0));
        add(1,  1,1,0,0,0, mk(0,1,1,0, 3,0,0));
        add(1,  1,1,0,0,0, mk(0,1,1,0, 4,0,0));
        add(1,  1,1,1,0,0, mk(0,1,1,0, 4,0,0));
        add(1,  1,1,0,0,0, mk(0,1,1,0, 5,0,0));
        add(1,  1,1,0,0,0, mk(0,1,1,0, 6,0,0));
        add(1,  1,1,0,0,0, mk(0,1,1,0, 7,0,0));
        add(1,  1,1,0,0,0, mk(1,0,0,0, 8,1,0));
        add(16, 1,0,0,0,0, mk(0,1,0,0, 8,1,0));
        add(1,  1,0,0,1,0, mk(0,1,0,0, 8,1,0));
        add(1,  1,0,0,0,0, mk(0,1,0,0, 8,1,0));
        add(1,  1,1,1,0,0, mk(0,1,1,0, 8,1,0));
        add(1,  1,0,0,1,0, mk(0,1,1,0, 8,1,1));
        add(1,  1,0,0,0,0, mk(0,1,1,0, 8,1,1));
        add(1,  1,0,0,1,0, mk(0,1,1,0, 8,1,2));
        add(1,  1,0,0,0,0, mk(0,1,1,0, 8,1,2));
        add(1,  1,0,0,1,0, mk(0,1,1,0, 8,1,3));
        add(5,  1,0,0,1,0, mk(0,1,1,0, 8,1,3));
        add(89, 1,0,0,1,0, mk(0,1,1,0, 8,1,3));
        add(1,  1,0,0,1,0, mk(1,0,0,0, 8,2,3));
        add(16, 1,0,0,1,0, mk(0,1,0,0, 8,2,3));
        add(1,  1,1,1,1,0, mk(0,1,1,0, 8,2,3));
        add(98, 1,0,0,1,0, mk(0,1,1,0, 8,2,3));
        add(1,  1,1,1,1,0, mk(0,1,1,0, 8,2,3));
        add(99, 1,0,0,1,0, mk(0,1,1,0, 8,2,3));
        add(1,  1,0,0,1,0, mk(1,0,0,0, 8,3,3));
        add(16, 1,0,0,1,0, mk(0,1,0,0, 8,3,3));
        add(1,  1,1,0,1,0, mk(0,1,0,0, 9,3,3));
        add(1,  1,1,0,1,0, mk(0,1,0,0, 10,3,3));
        add(1,  1,1,0,1,0, mk(0,1,0,0, 11,3,3));
        add(99, 1,0,0,1,0, mk(0,1,0,0, 11,3,3));
        add(1,  1,1,0,1,0, mk(1,0,0,0, 12,4,3));
        add(16, 1,0,0,1,0, mk(0,1,0,0, 12,4,3));
        add(99, 1,0,0,1,0, mk(0,1,0,0, 12,4,3));
        add(1,  0,0,0,1,0, mk(1,0,0,0, 12,4,3));

        #1;
        check("reset_values", mk(1,0,0,0, 0,0,0));
        #12;
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].n, vq[i].en, vq[i].pd, vq[i].ok,
                 vq[i].fr, vq[i].sw);
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        // Each retrain from OFF takes 1 + 16 + 100 edges, then 116 per retrain.
        step(1 + 116 * 251, 1, 0, 0, 1, 0);
        check("ret_reach_255", mk(1,0,0,0, 12,255,3));
        step(116 * 49, 1, 0, 0, 1, 0);
        check("ret_sat_255", mk(1,0,0,0, 12,255,3));

        step(1, 0, 0, 0, 1, 0);
        check("off_again", mk(1,0,0,0, 12,255,3));
        step(17, 1, 0, 0, 1, 0);
        check("acq_again", mk(0,1,0,0, 12,255,3));
        step(1, 1, 1, 1, 1, 1);
        check("lock_again", mk(0,1,1,1, 12,255,3));

        @(negedge clock);
        packet_done = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", mk(1,0,0,0, 0,0,0));
        @(negedge clock);
        reset_n = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        check("post_reset_off", mk(1,0,0,0, 0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csi_rx_link_supervisor.md
# csi_rx_link_supervisor

Link-level controller for the CSI-2 receive path. It sequences reset and enable of the byte aligner, word aligner and packet handler. It declares link lock once the first good packet arrives, and forces a retrain when packets stop or header ECC keeps failing. It sits between the control/status registers and the receive datapath, and consumes the packet handler's `sync_wait`, `packet_done`, ECC and frame flags.

## Interface
Parameters:
- `TIMEOUT_CYC`, 65535: cycles without `packet_done` before retrain; must be >= 2.
- `ERR_LIMIT`, 4: consecutive ECC-failed packets that force a retrain; must be >= 1.
- `HOLD_CYC`, 16: cycles the datapath reset is held on each (re)train; must be >= 1.

Ports:
- `clock`  in  1: single clock; all logic is in this domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `link_en`  in  1: software link enable, level-sensitive.
- `sync_wait`  in  1: packet handler idle / hunting for sync. Status only; it does not steer the FSM.
- `packet_done`  in  1: one-cycle pulse at end of each packet.
- `ecc_ok`  in  1: header ECC match. Valid only in the cycle `packet_done` = 1.
- `in_frame`  in  1: between FS and FE.
- `dp_reset`  out  1: active-high reset to aligners and packet handler.
- `dp_enable`  out  1: enable to aligners and packet handler.
- `link_up`  out  1: link locked.
- `hunting`  out  1: `link_up` & `sync_wait`.
- `retrain_cnt`  out  8: retrains caused by timeout or ECC. Saturates at 255.
- `ecc_err_cnt`  out  16: total packets with `ecc_ok` = 0 while enabled. Saturates at 65535.
- `frame_cnt`  out  16: FS edges seen while locked. Wraps.

## Operation
FSM states and behaviour:
- **OFF**: `dp_reset` = 1, `dp_enable` = 0. Goes to RESET when `link_en` = 1.
- **RESET**: `dp_reset` = 1, `dp_enable` = 0. The hold counter is cleared on entry and increments each cycle. Goes to ACQUIRE when hold counter = `HOLD_CYC`-1.
- **ACQUIRE**: `dp_reset` = 0, `dp_enable` = 1. Watchdog and consecutive-error counter are cleared on entry.
  - `packet_done` & `ecc_ok` → LOCKED.
  - `packet_done` & !`ecc_ok` → increment the error counters and stay, unless the error limit is reached.
- **LOCKED**: as ACQUIRE, plus `link_up` = 1.

Rules common to ACQUIRE and LOCKED:
- The watchdog increments every cycle and clears on `packet_done`.
- Retrain trigger A: watchdog = `TIMEOUT_CYC`-1 with no `packet_done` in that cycle.
- Retrain trigger B: a `packet_done` with !`ecc_ok` that makes the consecutive count equal `ERR_LIMIT`.
- Any retrain trigger → RESET, and `retrain_cnt` increments once even if both triggers fire together.
- A good packet clears the consecutive-error counter.

Priority and counting:
- `link_en` = 0 in any state → OFF next cycle. This has highest priority and is not counted as a retrain.
- `frame_cnt` increments on a 0→1 transition of `in_frame` (registered previous value) only while in LOCKED.
- `ecc_err_cnt` counts every !`ecc_ok` `packet_done` in ACQUIRE or LOCKED, including the one that triggers a retrain.
- Counters saturate or wrap as listed in Interface.

Widths:
- Watchdog: `$clog2(TIMEOUT_CYC)`.
- Hold counter: `$clog2(HOLD_CYC+1)`.
- Consecutive-error counter: `$clog2(ERR_LIMIT+1)`.

## Timing
- Reset values:
  - State = OFF.
  - `dp_reset` = 1, `dp_enable` = 0, `link_up` = 0, `hunting` = 0.
  - All counters = 0, previous-`in_frame` flop = 0.
- `dp_reset`, `dp_enable` and `link_up` decode the state register only (Moore); no input reaches them combinationally.
- `link_en` rising in the cycle before edge k:
  - RESET from edge k.
  - ACQUIRE from edge k+`HOLD_CYC`.
  - `dp_reset` is therefore high for exactly `HOLD_CYC` cycles after OFF.
- Lock latency: `link_up` rises at the edge that samples the first good `packet_done`.
- Retrain: state = RESET and `retrain_cnt` updates at the same edge that samples the trigger. `dp_reset` asserts in the following cycle.
- Simultaneous events:
  - `packet_done` and watchdog expiry in the same cycle: the packet wins and the watchdog clears. If that packet fails ECC and hits `ERR_LIMIT`, it is still a retrain, counted once.
  - `link_en` = 0 together with any trigger: OFF, with no count.
- Asynchronous `reset_n` mid-packet: all state is lost and the FSM returns to OFF immediately. Nothing is sampled until `reset_n` deasserts.

## Test plan
- Reset/enable: `HOLD_CYC`=16. Raise `link_en` → `dp_reset` high for exactly 16 cycles, then `dp_enable` = 1 and `link_up` = 0.
- Lock: in ACQUIRE, pulse `packet_done` with `ecc_ok` = 0, then with `ecc_ok` = 1 → `ecc_err_cnt` = 1 and `link_up` = 1 one edge after the good packet.
- Timeout: `TIMEOUT_CYC`=100 while locked, no packets → RESET 100 cycles after the last `packet_done`, `retrain_cnt` = 1. Repeat with `packet_done` in cycle 99 → no retrain.
- ECC limit: `ERR_LIMIT`=4. Send 3 bad, 1 good, 4 bad → retrain on the 8th packet, `ecc_err_cnt` = 7, `retrain_cnt` = 1.
- Frames: toggle `in_frame` 3 times while locked and once in ACQUIRE → `frame_cnt` = 3. Force 300 timeouts → `retrain_cnt` holds at 255.
- Override: drop `link_en` in the same cycle as a timeout → OFF, `retrain_cnt` unchanged. Assert `reset_n` = 0 mid-LOCKED → all outputs at reset values immediately.
